// File: rtl/stream_pkg.sv
// Shared types and helpers for the round-robin stream merger.
package stream_pkg;

    localparam int DEF_WIDTH = 32;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ACK  = 2'd1;
    localparam state_t ST_SEND = 2'd2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A single channel still needs a 1-bit index.
    function automatic int ch_bits(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
module rr_arbiter
    import stream_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CH_BITS = ch_bits(NUM_CH)
) (
    input  logic [NUM_CH-1:0]  i_req,
    input  logic [CH_BITS-1:0] i_ptr,
    output logic [NUM_CH-1:0]  o_grant,
    output logic [CH_BITS-1:0] o_idx,
    output logic               o_any
);

    logic w_found;
    logic w_hit;
    int   w_j;

    // Scan ptr, ptr+1, .. wrapping; the first hit wins and later hits are masked.
    always_comb begin
        o_grant = {NUM_CH{1'b0}};
        o_idx   = {CH_BITS{1'b0}};
        w_found = 1'b0;
        w_hit   = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_j          = (int'(i_ptr) + k) % NUM_CH;
            w_hit        = !w_found && i_req[w_j];
            o_grant[w_j] = o_grant[w_j] | w_hit;
            o_idx        = w_hit ? CH_BITS'(w_j) : o_idx;
            w_found      = w_found | w_hit;
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/stream_merge_rr.sv
// N:1 stb/ack stream merger with fair round-robin and a sticky first-fault flag.
module stream_merge_rr
    import stream_pkg::*;
#(
    parameter int                 NUM_CH   = 4,
    parameter int                 WIDTH    = DEF_WIDTH,
    parameter int                 CH_BITS  = ch_bits(NUM_CH),
    parameter logic [NUM_CH-1:0]  EXC_MASK = {NUM_CH{1'b1}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] input_in,
    input  logic [NUM_CH-1:0]       input_in_stb,
    output logic [NUM_CH-1:0]       input_in_ack,
    output logic [WIDTH-1:0]        output_out,
    output logic [CH_BITS-1:0]      output_out_ch,
    output logic                    output_out_stb,
    input  logic                    output_out_ack,
    input  logic [NUM_CH-1:0]       exception_in,
    input  logic                    exception_clr,
    output logic                    exception,
    output logic [CH_BITS-1:0]      exception_src
);

    function automatic logic [CH_BITS-1:0] lowest_set(input logic [NUM_CH-1:0] v);
        logic [CH_BITS-1:0] r;
        r = {CH_BITS{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            r = v[i] ? CH_BITS'(i) : r;
        end
        return r;
    endfunction

    state_t             r_state;
    logic [CH_BITS-1:0] r_ptr;
    logic [CH_BITS-1:0] r_grant;
    logic [NUM_CH-1:0]  r_ack;
    logic [WIDTH-1:0]   r_data;
    logic [CH_BITS-1:0] r_ch;
    logic               r_stb;
    logic               r_exc;
    logic [CH_BITS-1:0] r_exc_src;

    logic [NUM_CH-1:0]  w_grant_oh;
    logic [CH_BITS-1:0] w_grant_idx;
    logic               w_req_any;
    logic [CH_BITS-1:0] w_ptr_next;
    logic [NUM_CH-1:0]  w_exc_masked;

    rr_arbiter #(
        .NUM_CH  (NUM_CH),
        .CH_BITS (CH_BITS)
    ) u_arb (
        .i_req   (input_in_stb),
        .i_ptr   (r_ptr),
        .o_grant (w_grant_oh),
        .o_idx   (w_grant_idx),
        .o_any   (w_req_any)
    );

    // Channel just served drops to lowest priority.
    always_comb begin
        if (r_grant == CH_BITS'(NUM_CH - 1)) begin
            w_ptr_next = {CH_BITS{1'b0}};
        end else begin
            w_ptr_next = r_grant + CH_BITS'(1);
        end
    end

    // Grant / accept / present FSM; a source dropping stb during ACK is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= {CH_BITS{1'b0}};
            r_grant <= {CH_BITS{1'b0}};
            r_ack   <= {NUM_CH{1'b0}};
            r_data  <= {WIDTH{1'b0}};
            r_ch    <= {CH_BITS{1'b0}};
            r_stb   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= {NUM_CH{1'b0}};
                    if (w_req_any) begin
                        r_grant <= w_grant_idx;
                        r_ack   <= w_grant_oh;
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_ack <= {NUM_CH{1'b0}};
                    if (input_in_stb[r_grant]) begin
                        r_data  <= input_in[r_grant*WIDTH +: WIDTH];
                        r_ch    <= r_grant;
                        r_stb   <= 1'b1;
                        r_state <= ST_SEND;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (output_out_ack) begin
                        r_stb   <= 1'b0;
                        r_ptr   <= w_ptr_next;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_ack   <= {NUM_CH{1'b0}};
                    r_stb   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_exc_masked = exception_in & EXC_MASK;

    // Sticky first-fault capture; a new event in the clear cycle reloads the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exc     <= 1'b0;
            r_exc_src <= {CH_BITS{1'b0}};
        end else if ((|w_exc_masked) && (!r_exc || exception_clr)) begin
            r_exc     <= 1'b1;
            r_exc_src <= lowest_set(w_exc_masked);
        end else if (exception_clr) begin
            r_exc     <= 1'b0;
            r_exc_src <= {CH_BITS{1'b0}};
        end
    end

    assign input_in_ack   = r_ack;
    assign output_out     = r_data;
    assign output_out_ch  = r_ch;
    assign output_out_stb = r_stb;
    assign exception      = r_exc;
    assign exception_src  = r_exc_src;

endmodule

// File: tb/tb_stream_merge_rr.sv
// Directed self-checking bench for stream_merge_rr (4 channels, bit2 exception masked).
module tb_stream_merge_rr;

    localparam int NUM_CH  = 4;
    localparam int WIDTH   = 32;
    localparam int CH_BITS = 2;

    logic                    clk;
    logic                    rst;
    logic [NUM_CH*WIDTH-1:0] input_in;
    logic [NUM_CH-1:0]       input_in_stb;
    logic [NUM_CH-1:0]       input_in_ack;
    logic [WIDTH-1:0]        output_out;
    logic [CH_BITS-1:0]      output_out_ch;
    logic                    output_out_stb;
    logic                    output_out_ack;
    logic [NUM_CH-1:0]       exception_in;
    logic                    exception_clr;
    logic                    exception;
    logic [CH_BITS-1:0]      exception_src;

    int n_checks;
    int n_errors;

    stream_merge_rr #(
        .NUM_CH   (NUM_CH),
        .WIDTH    (WIDTH),
        .CH_BITS  (CH_BITS),
        .EXC_MASK (4'b1011)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .input_in       (input_in),
        .input_in_stb   (input_in_stb),
        .input_in_ack   (input_in_ack),
        .output_out     (output_out),
        .output_out_ch  (output_out_ch),
        .output_out_stb (output_out_stb),
        .output_out_ack (output_out_ack),
        .exception_in   (exception_in),
        .exception_clr  (exception_clr),
        .exception      (exception),
        .exception_src  (exception_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stb(input string tag);
        int n;
        n = 0;
        while (!output_out_stb && n < 12) begin
            tick();
            n = n + 1;
        end
        chk({tag, "_timeout"}, 64'(output_out_stb), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},  64'(input_in_ack),   64'd0);
        chk({tag, "_stb"},  64'(output_out_stb), 64'd0);
        chk({tag, "_data"}, 64'(output_out),     64'd0);
        chk({tag, "_ch"},   64'(output_out_ch),  64'd0);
        chk({tag, "_exc"},  64'(exception),      64'd0);
        chk({tag, "_src"},  64'(exception_src),  64'd0);
    endtask

    initial begin
        logic [CH_BITS-1:0] rr_seq [5];
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        input_in       = {NUM_CH*WIDTH{1'b0}};
        input_in_stb   = 4'b0000;
        output_out_ack = 1'b1;
        exception_in   = 4'b0000;
        exception_clr  = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Single transfer from ch2: ack at N+1, output at N+2.
        input_in[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
        input_in_stb = 4'b0100;
        tick();
        chk("single_ack",     64'(input_in_ack),   64'h4);
        chk("single_stb_n1",  64'(output_out_stb), 64'd0);
        tick();
        chk("single_ack_off", 64'(input_in_ack),   64'h0);
        chk("single_stb",     64'(output_out_stb), 64'd1);
        chk("single_data",    64'(output_out),     64'hDEADBEEF);
        chk("single_ch",      64'(output_out_ch),  64'd2);
        input_in_stb = 4'b0000;
        tick();
        chk("single_done",    64'(output_out_stb), 64'd0);

        // Round-robin from a fresh pointer with every channel requesting.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            input_in[i*WIDTH +: WIDTH] = 32'h1000_0000 + 32'(i);
        end
        input_in_stb = 4'b1111;
        rr_seq[0] = 2'd0;
        rr_seq[1] = 2'd1;
        rr_seq[2] = 2'd2;
        rr_seq[3] = 2'd3;
        rr_seq[4] = 2'd0;
        for (int i = 0; i < 5; i++) begin
            wait_stb("rr");
            chk("rr_ch",   64'(output_out_ch), 64'(rr_seq[i]));
            chk("rr_data", 64'(output_out),    64'h1000_0000 + 64'(rr_seq[i]));
            tick();
        end
        input_in_stb = 4'b0000;

        // Backpressure: output held, no input acks while downstream stalls.
        output_out_ack = 1'b0;
        input_in[3*WIDTH +: WIDTH] = 32'hCAFEF00D;
        input_in_stb = 4'b1000;
        wait_stb("bp");
        input_in_stb = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_stb",  64'(output_out_stb), 64'd1);
            chk("bp_data", 64'(output_out),     64'hCAFEF00D);
            chk("bp_ch",   64'(output_out_ch),  64'd3);
            chk("bp_ack",  64'(input_in_ack),   64'd0);
        end
        output_out_ack = 1'b1;
        tick();
        chk("bp_release", 64'(output_out_stb), 64'd0);

        // Protocol violation: ch1 withdraws stb during its ack cycle.
        input_in[1*WIDTH +: WIDTH] = 32'h5555AAAA;
        input_in_stb = 4'b0010;
        tick();
        chk("viol_ack", 64'(input_in_ack), 64'h2);
        input_in_stb = 4'b0000;
        tick();
        chk("viol_stb",  64'(output_out_stb), 64'd0);
        chk("viol_data", 64'(output_out),     64'hCAFEF00D);
        tick();
        chk("viol_idle_ack", 64'(input_in_ack),   64'd0);
        chk("viol_idle_stb", 64'(output_out_stb), 64'd0);

        // Reset while presenting a word aborts it.
        output_out_ack = 1'b0;
        input_in[0*WIDTH +: WIDTH] = 32'h12345678;
        input_in_stb = 4'b0001;
        wait_stb("rst_send");
        chk("rst_send_data", 64'(output_out), 64'h12345678);
        input_in_stb = 4'b0000;
        rst = 1'b1;
        tick();
        chk_reset_outputs("rst_send");
        rst = 1'b0;
        output_out_ack = 1'b1;
        tick();
        chk("rst_after_stb", 64'(output_out_stb), 64'd0);

        // Exceptions: first lowest source sticks, clear race reloads, masked bit ignored.
        exception_in = 4'b1010;
        chk("exc_latency", 64'(exception), 64'd0);
        tick();
        chk("exc_set",     64'(exception),     64'd1);
        chk("exc_src",     64'(exception_src), 64'd1);
        exception_in = 4'b0001;
        tick();
        chk("exc_sticky",  64'(exception),     64'd1);
        chk("exc_src_keep",64'(exception_src), 64'd1);
        exception_in  = 4'b1000;
        exception_clr = 1'b1;
        tick();
        chk("clr_race",     64'(exception),     64'd1);
        chk("clr_race_src", 64'(exception_src), 64'd3);
        exception_in = 4'b0000;
        tick();
        chk("clr",     64'(exception),     64'd0);
        chk("clr_src", 64'(exception_src), 64'd0);
        exception_clr = 1'b0;
        exception_in  = 4'b0100;
        tick();
        tick();
        chk("masked",     64'(exception),     64'd0);
        chk("masked_src", 64'(exception_src), 64'd0);
        exception_in = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
